rr_arbiter: RTL
===============

# rr_arbiter

Round-robin arbiter that shares one downstream resource among eight requesters, such as the LED/seven-segment display path driven by the 8-to-3 encoder. It replaces the encoder's fixed priority with rotating priority. Each grant is held until the owner releases it, signals completion, or hits a hold timeout. `gnt_idx` is the 3-bit index that feeds the segment decoder directly; `any_req` has the same meaning as the existing encoder `flag`.

## Interface
- `N`, 8: number of requesters. Fixed at 8; `gnt_idx` is 3 bits.
- `HOLD_MAX`, 16: maximum number of consecutive cycles one grant may be held. Legal range 1..255.
- `CNTW`, 8: width of the hold counter. Must satisfy 2^CNTW > HOLD_MAX.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 8: request vector; bit i high means requester i wants the resource.
- `en` input 1: arbiter enable.
- `done` input 1: owner completion pulse, sampled only while `gnt_vld`=1.
- `gnt` output 8: one-hot grant, registered.
- `gnt_idx` output 3: index of the current grant, registered. It is 0 when `gnt_vld`=0.
- `gnt_vld` output 1: a grant is active; equals OR of `gnt`.
- `any_req` output 1: combinational; 1 iff `en`=1 and `req`!=0.
- `timeout` output 1: one-cycle pulse marking a release forced by hold expiry.

## Operation
- State machine with two states:
  - IDLE (`gnt_vld`=0)
  - GRANT (`gnt_vld`=1)
- Internal registers:
  - `last`, 3 bits: index of the most recent grant.
  - `cnt`, CNTW bits: hold counter.
- Reset values: state IDLE, `gnt`=0, `gnt_idx`=0, `gnt_vld`=0, `timeout`=0, `cnt`=0, `last`=7. With `last`=7, the first search starts at index 0.
- IDLE, when `en`=1 and `req`!=0:
  - Select the first set bit of `req`, scanning (last+1) mod 8, (last+2) mod 8, … and wrapping around.
  - At the next edge: `gnt`=1<<sel, `gnt_idx`=sel, `cnt`=0, go to GRANT.
- IDLE, otherwise: remain in IDLE; outputs stay zero.
- GRANT: release at the next edge if any of the following hold:
  - `done`=1
  - `req[gnt_idx]`=0
  - `en`=0
  - `cnt`==HOLD_MAX-1
- GRANT, on release: `gnt`=0, `gnt_idx`=0, `last`=released index, `cnt`=0, go to IDLE. Otherwise `cnt` increments.
- `timeout` is set to 1 at the release edge only when hold expiry is the sole cause. `done`, request drop and `en`=0 take precedence. It clears at the following edge.
- Requests from other requesters arriving during GRANT are ignored until the next IDLE evaluation. There is no preemption.
- If the owner keeps its request high after release, it has the lowest priority in the next search. It is re-granted only if no other requester is asserting.

## Timing
- Grant latency: a request first seen high in IDLE at edge k produces `gnt` high during the cycle after edge k.
- Gap between grants: there is exactly one cycle with `gnt_vld`=0 between consecutive grants (the IDLE evaluation cycle). Back-to-back grants never overlap.
- Maximum hold: `gnt` is high for at most HOLD_MAX consecutive cycles. With the default, that is 16 cycles.
- `done` and the request drop each take effect at the first edge they are sampled high/low; release is seen one cycle later.
- `timeout` is high during the single cycle immediately after the release edge, i.e. the IDLE gap cycle.
- `any_req` has zero latency.
- Reset mid-grant: `rst`=1 at any edge forces all reset values at that edge, including `last`=7. No `timeout` pulse is produced.

## Test plan
- Reset, then `req`=8'b0000_0100, `en`=1, with `done` pulsed on the 3rd grant cycle:
  - One cycle later: `gnt`=8'h04, `gnt_idx`=2, `gnt_vld`=1.
  - Release at the edge after `done`; `timeout` stays 0.
- `req`=8'hFF held constant, `done` pulsed on each grant's first cycle:
  - Grant order is 0,1,…,7,0, with one idle cycle between each pair.
- `req`=8'h01 held, `done`=0:
  - `gnt`=8'h01 for exactly 16 cycles.
  - `timeout`=1 for one cycle, then re-grant to 0.
- `req`=8'h81 held, `HOLD_MAX`=4:
  - Grants alternate 0,7,0,7, each lasting 4 cycles.
  - `timeout` pulses after every grant.
- During a grant to 5, drop `en`:
  - Release at the next edge; `gnt_idx`=0; `timeout`=0; no new grant while `en`=0.
  - `any_req`=0 while `en`=0.
- Assert `rst` during a grant to 3 with `req`=8'h0A:
  - All outputs go to zero at that edge.
  - After `rst` deasserts, the first grant goes to 1, since the search restarts from index 0.

Source files
------------

// File: rtl/rr_arbiter.sv
// rr_arbiter: eight-way round-robin arbiter with hold-until-release grants and a hold timeout.
module rr_arbiter #(
    parameter int N        = 8,
    parameter int HOLD_MAX = 16,
    parameter int CNTW     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic [2:0]   gnt_idx,
    output logic         gnt_vld,
    output logic         any_req,
    output logic         timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t            state, state_n;
    logic [N-1:0]      gnt_n;
    logic [2:0]        idx_n, last, last_n, sel;
    logic [CNTW-1:0]   cnt, cnt_n;
    logic              to_n, found, expire, drop, rel;
    assign any_req = en && |req;
    assign gnt_vld = state == GRANT;
    assign expire  = cnt == CNTW'(HOLD_MAX - 1);
    assign drop    = done || !req[gnt_idx] || !en;
    assign rel     = drop || expire;
    // Scan starts just after the last owner, so it lands on itself only if nobody else asks.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!found && req[3'(last + 3'(i))]) begin
                sel   = 3'(last + 3'(i));
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        idx_n   = gnt_idx;
        last_n  = last;
        cnt_n   = cnt;
        to_n    = 1'b0;
        if (state == IDLE) begin
            if (any_req) begin
                state_n = GRANT;
                gnt_n   = N'(1) << sel;
                idx_n   = sel;
                cnt_n   = '0;
            end
        end else if (rel) begin
            state_n = IDLE;
            gnt_n   = '0;
            idx_n   = '0;
            last_n  = gnt_idx;
            cnt_n   = '0;
            to_n    = !drop;
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            last    <= 3'd7;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_idx <= idx_n;
            last    <= last_n;
            cnt     <= cnt_n;
            timeout <= to_n;
        end
    end
endmodule
